// File: rtl/note_envelope.sv
// note_envelope: articulation stage of the music-box tone generator.
// Takes the raw square wave plus per-slot note information, shapes an
// ADSR-style amplitude envelope, and applies it to the buzzer as PWM gating.
// Repeated identical notes are separated by a short silent gap, and rests
// fade out through RELEASE instead of cutting off hard.

module note_envelope #(
    parameter int ENV_DIV     = 25000,  // clk0 cycles per envelope tick
    parameter int ATTACK_STEP = 32,     // level increment per tick in ATTACK
    parameter int DECAY_STEP  = 4,      // level decrement per tick in DECAY/RELEASE
    parameter int SUSTAIN_LVL = 160,    // level held in SUSTAIN
    parameter int GAP_TICKS   = 20      // silent ticks before a retriggered note
) (
    input  logic       clk0,
    input  logic       rst,          // asynchronous, active-low
    input  logic       enable,
    input  logic       note_strobe,
    input  logic [7:0] note_code,
    input  logic       tie,
    input  logic       tone_in,
    output logic       buz_out,
    output logic [7:0] level,
    output logic [2:0] env_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4,
        GAP     = 3'd5
    } env_state_t;

    // Prescaler sized to hold ENV_DIV-1 (ENV_DIV is at least 2).
    localparam int              PRE_W    = $clog2(ENV_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(ENV_DIV - 1);

    // Envelope arithmetic is done 10 bits wide so that sums and
    // differences never wrap before they are clamped.
    localparam logic [9:0] ATT_STEP_W = 10'(ATTACK_STEP);
    localparam logic [9:0] DEC_STEP_W = 10'(DECAY_STEP);
    localparam logic [9:0] SUS_LVL_W  = 10'(SUSTAIN_LVL);
    localparam logic [9:0] LVL_MAX_W  = 10'd255;
    localparam logic [7:0] SUS_LVL_8  = 8'(SUSTAIN_LVL);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    env_state_t       state_q,     state_d;
    logic [7:0]       level_q,     level_d;
    logic [7:0]       prev_code_q, prev_code_d;
    logic [PRE_W-1:0] pre_q,       pre_d;
    logic [7:0]       pwm_cnt_q,   pwm_cnt_d;
    logic [7:0]       gap_cnt_q,   gap_cnt_d;
    logic             buz_q,       buz_d;

    logic             tick;
    logic [9:0]       level_w;
    logic [9:0]       attack_sum;
    logic [7:0]       attack_lvl;
    logic [7:0]       decay_lvl;
    logic [7:0]       release_lvl;
    logic             same_note;
    logic             held_state;

    // Envelope tick prescaler: counts 0..ENV_DIV-1 while enabled, pulses tick on the last count.
    always_comb begin
        tick  = enable && (pre_q == PRE_MAX);
        pre_d = pre_q + 1'b1;
        if (!enable || tick) begin
            pre_d = '0;
        end
    end

    // PWM carrier and buzzer gating; buzzer follows the registered level with one cycle of latency.
    always_comb begin
        pwm_cnt_d = enable ? (pwm_cnt_q + 8'd1) : 8'd0;
        buz_d     = enable && tone_in && (pwm_cnt_q < level_q);
    end

    // Clamped envelope step results for each ramping state.
    always_comb begin
        level_w     = {2'b00, level_q};
        attack_sum  = level_w + ATT_STEP_W;
        attack_lvl  = (attack_sum > LVL_MAX_W) ? 8'hFF : attack_sum[7:0];
        decay_lvl   = (level_w >= SUS_LVL_W + DEC_STEP_W) ? 8'(level_w - DEC_STEP_W) : SUS_LVL_8;
        release_lvl = (level_w >= DEC_STEP_W) ? 8'(level_w - DEC_STEP_W) : 8'd0;
    end

    // Envelope FSM: strobe decode takes priority over the tick it may coincide with.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        level_d     = level_q;
        prev_code_d = prev_code_q;
        gap_cnt_d   = gap_cnt_q;

        same_note  = (note_code == prev_code_q);
        held_state = (state_q != IDLE) && (state_q != RELEASE);

        if (!enable) begin
            state_d     = IDLE;
            level_d     = 8'd0;
            prev_code_d = 8'd0;
            gap_cnt_d   = 8'd0;
        end else if (note_strobe) begin
            if (note_code == 8'd0) begin
                // Rest: fade out whatever is sounding.
                if (state_q != IDLE) begin
                    state_d = RELEASE;
                end
                prev_code_d = 8'd0;
            end else begin
                if (!same_note) begin
                    // New pitch: legato attack from the current level.
                    state_d = ATTACK;
                end else if (!(tie && held_state)) begin
                    // Repeated note without a tie: silent gap, then re-attack.
                    state_d   = GAP;
                    level_d   = 8'd0;
                    gap_cnt_d = 8'd0;
                end
                prev_code_d = note_code;
            end
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    level_d = 8'd0;
                end
                ATTACK: begin
                    level_d = attack_lvl;
                    if (attack_lvl == 8'hFF) begin
                        state_d = DECAY;
                    end
                end
                DECAY: begin
                    level_d = decay_lvl;
                    if (decay_lvl == SUS_LVL_8) begin
                        state_d = SUSTAIN;
                    end
                end
                SUSTAIN: begin
                    level_d = level_q;
                end
                RELEASE: begin
                    level_d = release_lvl;
                    if (release_lvl == 8'd0) begin
                        state_d = IDLE;
                    end
                end
                GAP: begin
                    level_d = 8'd0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ATTACK;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = 8'd0;
                end
            endcase
        end
    end

    // All state registers, cleared asynchronously by rst.
    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            level_q     <= 8'd0;
            prev_code_q <= 8'd0;
            pre_q       <= '0;
            pwm_cnt_q   <= 8'd0;
            gap_cnt_q   <= 8'd0;
            buz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            state_q     <= state_d;
            level_q     <= level_d;
            prev_code_q <= prev_code_d;
            pre_q       <= pre_d;
            pwm_cnt_q   <= pwm_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            buz_q       <= buz_d;
        end
    end

    assign buz_out   = buz_q;
    assign level     = level_q;
    assign env_state = state_q;

endmodule
